// File: rtl/sfifo_arbiter_pkg.sv
// ============================================================================
// Module   : sfifo_arbiter_pkg
// Brief    : Shared types for the SFifo push-port round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfifo_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sfifo_arbiter_rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational rotating priority encoder (first request at or
//            cyclically after ptr wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]         req,
    input  logic [$clog2(NSRC)-1:0] ptr,
    output logic [$clog2(NSRC)-1:0] winner,
    output logic                    any_valid
);

    localparam int c_IW = $clog2(NSRC);

    logic [2*NSRC-1:0] w_dbl;
    logic [2*NSRC-1:0] w_masked;
    logic              w_found;

    // Lower copy is masked below ptr; the upper copy supplies the wrap-around.
    always_comb begin
        w_dbl     = {req, req};
        w_masked  = '0;
        winner    = '0;
        w_found   = 1'b0;
        any_valid = |req;
        for (int i = 0; i < 2*NSRC; i++) begin
            w_masked[i] = w_dbl[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < 2*NSRC; i++) begin
            if (w_masked[i] && !w_found) begin
                w_found = 1'b1;
                winner  = (i >= NSRC) ? c_IW'(i - NSRC) : c_IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sfifo_arbiter.sv
// ============================================================================
// Module   : sfifo_arbiter
// Brief    : Round-robin burst arbiter sharing one SFifo push port among NSRC
//            rdy/ack producers. Optional macro SFIFO_ARBITER_STALL_CNT_EN adds
//            a saturating stall-cycle counter output (o_stall_cnt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfifo_arbiter
    import sfifo_arbiter_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int BW    = 8,
    parameter int BURST = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NSRC-1:0]         src_rdy,
    output logic [NSRC-1:0]         src_ack,
    input  logic [BW-1:0]           i_data [NSRC],
    output logic                    dst_rdy,
    input  logic                    dst_ack,
    output logic [BW-1:0]           o_data,
`ifdef SFIFO_ARBITER_STALL_CNT_EN
    output logic [15:0]             o_stall_cnt,
`endif
    output logic [$clog2(NSRC)-1:0] o_id
);

    localparam int c_IW = $clog2(NSRC);
    localparam int c_CW = $clog2(BURST + 1);

    if (NSRC < 2) begin : g_bad_nsrc
        $fatal(1, "sfifo_arbiter: NSRC must be >= 2");
    end
    if (BURST < 1) begin : g_bad_burst
        $fatal(1, "sfifo_arbiter: BURST must be >= 1");
    end

    arb_state_t        r_state, w_state_nxt;
    logic [c_IW-1:0]   r_owner, w_owner_nxt;
    logic [c_IW-1:0]   r_ptr,   w_ptr_nxt;
    logic [c_CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [c_IW-1:0]   w_winner;
    logic              w_any;
    logic              w_xfer;

    rr_priority_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .req       (src_rdy),
        .ptr       (r_ptr),
        .winner    (w_winner),
        .any_valid (w_any)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        dst_rdy     = 1'b0;
        src_ack     = '0;
        o_data      = i_data[r_owner];
        o_id        = r_owner;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                dst_rdy          = src_rdy[r_owner];
                src_ack[r_owner] = dst_ack;
                w_xfer           = dst_rdy && dst_ack;
                // Ownership ends on a completed burst or when the owner runs dry.
                if ((w_xfer && (r_cnt == c_CW'(BURST - 1))) || !src_rdy[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_owner == c_IW'(NSRC - 1)) ? '0 : r_owner + 1'b1;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SFIFO_ARBITER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= '0;
        end else if (dst_rdy && !dst_ack && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sfifo_arbiter.sv
// ============================================================================
// Module   : tb_sfifo_arbiter
// Brief    : Self-checking bench for sfifo_arbiter (vector table, burst
//            scoreboard, reset and stall sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfifo_arbiter;

    localparam int NSRC  = 4;
    localparam int BW    = 8;
    localparam int BURST = 4;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [NSRC-1:0] src_rdy;
    logic [NSRC-1:0] src_ack;
    logic [BW-1:0]   i_data [NSRC];
    logic            dst_rdy;
    logic            dst_ack;
    logic [BW-1:0]   o_data;
    logic [1:0]      o_id;
`ifdef SFIFO_ARBITER_STALL_CNT_EN
    logic [15:0]     o_stall_cnt;
`endif

    sfifo_arbiter #(
        .NSRC  (NSRC),
        .BW    (BW),
        .BURST (BURST)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .src_rdy     (src_rdy),
        .src_ack     (src_ack),
        .i_data      (i_data),
        .dst_rdy     (dst_rdy),
        .dst_ack     (dst_ack),
        .o_data      (o_data),
`ifdef SFIFO_ARBITER_STALL_CNT_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .o_id        (o_id)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0] rdy;
        logic       ack;
        logic       exp_drdy;
        logic [3:0] exp_sack;
        logic [1:0] exp_id;
    } vec_t;

    typedef struct {
        logic [1:0]    id;
        logic [BW-1:0] data;
    } xfer_t;

    vec_t  tv [26];
    xfer_t sb_q [$];
    xfer_t sb_e;
    int    word [NSRC];
    int    n_vec = 0;
    int    n_err = 0;

    // Payload encodes channel and word number so the scoreboard sees ordering.
    task automatic set_data();
        for (int k = 0; k < NSRC; k++) begin
            i_data[k] = {2'(k), 6'(word[k])};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rdy, input logic ack, input logic drdy,
                                input logic [3:0] sack, input logic [1:0] id);
        vec_t v;
        v.rdy = rdy; v.ack = ack; v.exp_drdy = drdy; v.exp_sack = sack; v.exp_id = id;
        return v;
    endfunction

    task automatic do_reset(input logic [3:0] rdy, input logic ack);
        i_rst   = 1'b0;
        src_rdy = rdy;
        dst_ack = ack;
        for (int k = 0; k < NSRC; k++) word[k] = 0;
        set_data();
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [3:0] acked;
        int         nxf;
        int         t;

        // c0..c25: full-rotation bursts, lone ch2 with early drop, ch1 stalled mid-burst
        t = 0;
        tv[t++] = mk(4'b1111, 1, 0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) tv[t++] = mk(4'b1111, 1, 1, 4'b0001, 0);
        tv[t++] = mk(4'b1111, 1, 0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) tv[t++] = mk(4'b1111, 1, 1, 4'b0010, 1);
        tv[t++] = mk(4'b0100, 1, 0, 4'b0000, 1);
        tv[t++] = mk(4'b0100, 1, 1, 4'b0100, 2);
        tv[t++] = mk(4'b0100, 1, 1, 4'b0100, 2);
        tv[t++] = mk(4'b0000, 0, 0, 4'b0000, 2);
        tv[t++] = mk(4'b0010, 1, 0, 4'b0000, 2);
        tv[t++] = mk(4'b0010, 1, 1, 4'b0010, 1);
        for (int i = 0; i < 5; i++) tv[t++] = mk(4'b0010, 0, 1, 4'b0000, 1);
        for (int i = 0; i < 3; i++) tv[t++] = mk(4'b0010, 1, 1, 4'b0010, 1);
        tv[t++] = mk(4'b0010, 1, 0, 4'b0000, 1);
        tv[t++] = mk(4'b0010, 1, 1, 4'b0010, 1);

        // ---------------- reset state with all channels requesting
        do_reset(4'b1111, 1'b1);
        @(negedge i_clk);
        chk("reset outputs", {27'd0, dst_rdy, src_ack}, 32'd0);
        chk("reset o_id", {30'd0, o_id}, 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;

        // ---------------- vector table
        for (int i = 0; i < t; i++) begin
            src_rdy = tv[i].rdy;
            dst_ack = tv[i].ack;
            @(negedge i_clk);
            chk($sformatf("vec %0d {drdy,sack,id,data}", i),
                {16'd0, dst_rdy, src_ack, o_id, o_data},
                {16'd0, tv[i].exp_drdy, tv[i].exp_sack, tv[i].exp_id, tv[i].exp_id, 6'd0});
            @(posedge i_clk);
            #1;
        end

        // ---------------- scoreboard: all ready, FIFO never stalls
        do_reset(4'b1111, 1'b1);
        for (int k = 0; k < NSRC; k++)
            for (int w = 0; w < BURST; w++) begin
                sb_e.id   = 2'(k);
                sb_e.data = {2'(k), 6'(w)};
                sb_q.push_back(sb_e);
            end
        i_rst = 1'b1;
        nxf   = 0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge i_clk);
            acked = src_ack & src_rdy;
            if (dst_rdy && dst_ack) begin
                nxf++;
                if (sb_q.size() == 0) begin
                    chk($sformatf("sb extra xfer c%0d", c), 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk($sformatf("sb xfer c%0d {id,data}", c), {22'd0, o_id, o_data},
                        {22'd0, sb_e.id, sb_e.data});
                    chk($sformatf("sb ack c%0d", c), {28'd0, acked}, 32'(1 << sb_e.id));
                end
            end
            if (c == 5 || c == 10 || c == 15 || c == 20)
                chk($sformatf("sb bubble c%0d", c), {31'd0, dst_rdy}, 32'd0);
            @(posedge i_clk);
            #1;
            for (int k = 0; k < NSRC; k++) if (acked[k]) word[k]++;
            set_data();
        end
        chk("sb transfers in 20 cycles", 32'(nxf), 32'd16);
        chk("sb leftover", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // ---------------- asynchronous reset mid-burst (owner 3, cnt 2)
        do_reset(4'b1000, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid c0 idle", {31'd0, dst_rdy}, 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("mid c1 grant3", {25'd0, dst_rdy, src_ack, o_id}, {25'd0, 1'b1, 4'b1000, 2'd3});
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        dst_ack = 1'b0;
        #2 i_rst = 1'b0;
        #1;
        chk("async reset {drdy,sack,id}", {25'd0, dst_rdy, src_ack, o_id}, 32'd0);
        src_rdy = 4'b1001;
        dst_ack = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        chk("post-reset idle", {25'd0, dst_rdy, src_ack, o_id}, 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("post-reset ch0 first", {25'd0, dst_rdy, src_ack, o_id}, {25'd0, 1'b1, 4'b0001, 2'd0});

`ifdef SFIFO_ARBITER_STALL_CNT_EN
        // ---------------- stall counter
        do_reset(4'b0001, 1'b0);
        chk("stall reset", 32'(o_stall_cnt), 32'd0);
        i_rst = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;
        chk("stall 7", 32'(o_stall_cnt), 32'd7);
        repeat (70000) @(posedge i_clk);
        #1;
        chk("stall saturate", 32'(o_stall_cnt), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
